button_event_ctrl: RTL and testbench

Controller that sequences a bank of button debouncers and arbitrates their outputs. It generates the shared debounce `tick` strobe from `clk`. It converts each debounced button level into press, long-press, auto-repeat and release events. Events from all buttons are merged onto a single valid/ready event port using round-robin arbitration; the port feeds the UI/menu logic.

---
 rtl/button_event_ctrl.sv | 170 +++++++++++++++++
 tb/tb_button_event_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Button event controller: generates the shared debounce tick, turns debounced
// levels into press/long/repeat/release events, and merges them round-robin.
module button_event_ctrl #(
   parameter int N_BTN        = 4,
   parameter int TICK_DIV     = 8,
   parameter int LONG_TICKS   = 16,
   parameter int REPEAT_TICKS = 4,
   parameter int ID_W         = (N_BTN > 2) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst_sync,
   output logic             tick,
   input  logic [N_BTN-1:0] btn_level,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output logic [1:0]       evt_kind,
   output logic             overflow,
   input  logic             ovf_clr
);

   // Handshake: an event transfers on every rising clk edge where evt_valid and
   // evt_ready are both 1; while evt_valid & ~evt_ready, evt_id/evt_kind hold.

   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int HOLD_W = $clog2(LONG_TICKS + 1);
   localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS);
   localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N_BTN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_RPT  = 2'd2
   } btn_state_t;

   // Per-button FSM state, kept in one array so it can be probed hierarchically.
   btn_state_t state [N_BTN];

   logic [CNT_W-1:0]          cnt;
   logic [N_BTN-1:0]          level_d;
   logic [N_BTN-1:0]          rise;
   logic [N_BTN-1:0]          fall;
   logic [HOLD_W-1:0]         hold_cnt [N_BTN];
   logic [REP_W-1:0]          rep_cnt  [N_BTN];
   logic [HOLD_W-1:0]         hold_inc [N_BTN];
   logic [REP_W-1:0]          rep_inc  [N_BTN];
   logic [N_BTN-1:0][3:0]     pend;
   logic [N_BTN-1:0][3:0]     set_bits;
   logic [N_BTN-1:0][3:0]     clr_bits;
   logic [ID_W-1:0]           rr;
   logic                      found;
   logic [ID_W-1:0]           win_id;
   logic [1:0]                win_kind;
   logic                      out_free;
   logic                      load;
   logic                      ovf_hit;

   assign tick     = (cnt == CNT_LAST);
   assign rise     = btn_level & ~level_d;
   assign fall     = ~btn_level & level_d;
   assign out_free = ~evt_valid | evt_ready;
   assign load     = out_free & found;

   always_ff @(posedge clk) begin
      if (rst_sync) begin
         cnt     <= '0;
         level_d <= '0;
      end else begin
         cnt     <= tick ? '0 : cnt + CNT_W'(1);
         level_d <= btn_level;
      end
   end

   // Event decode; bit index equals the evt_kind encoding.
   always_comb begin
      set_bits = '0;
      for (int b = 0; b < N_BTN; b++) begin
         hold_inc[b]    = hold_cnt[b] + HOLD_W'(1);
         rep_inc[b]     = rep_cnt[b] + REP_W'(1);
         set_bits[b][0] = rise[b] && (state[b] == ST_IDLE);
         set_bits[b][1] = !fall[b] && tick && (state[b] == ST_HELD) && (hold_inc[b] == HOLD_LAST);
         set_bits[b][2] = !fall[b] && tick && (state[b] == ST_RPT) && (rep_inc[b] == REP_LAST);
         set_bits[b][3] = fall[b];
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < N_BTN; b++) begin
         if (rst_sync) begin
            state[b]    <= ST_IDLE;
            hold_cnt[b] <= '0;
            rep_cnt[b]  <= '0;
         end else if (fall[b]) begin
            state[b] <= ST_IDLE;
         end else begin
            case (state[b])
               ST_IDLE: if (rise[b]) begin
                  state[b]    <= ST_HELD;
                  hold_cnt[b] <= '0;
               end
               ST_HELD: if (tick) begin
                  hold_cnt[b] <= hold_inc[b];
                  if (set_bits[b][1]) begin
                     state[b]   <= ST_RPT;
                     rep_cnt[b] <= '0;
                  end
               end
               ST_RPT: if (tick) begin
                  rep_cnt[b] <= set_bits[b][2] ? '0 : rep_inc[b];
               end
               default: state[b] <= ST_IDLE;
            endcase
         end
      end
   end

   // Round-robin search from rr with wrap, then fixed kind priority.
   always_comb begin
      found    = 1'b0;
      win_id   = '0;
      win_kind = 2'd0;
      for (int i = 0; i < N_BTN; i++) begin
         int idx;
         idx = int'(rr) + i;
         if (idx >= N_BTN) idx = idx - N_BTN;
         if (!found && (|pend[idx])) begin
            found  = 1'b1;
            win_id = ID_W'(idx);
            if (pend[idx][0])      win_kind = 2'd0;
            else if (pend[idx][1]) win_kind = 2'd1;
            else if (pend[idx][2]) win_kind = 2'd2;
            else                   win_kind = 2'd3;
         end
      end
   end

   always_comb begin
      clr_bits = '0;
      if (load) clr_bits[win_id] = 4'b0001 << win_kind;
      ovf_hit = |(set_bits & pend & ~clr_bits);
   end

   always_ff @(posedge clk) begin
      if (rst_sync) begin
         pend      <= '0;
         overflow  <= 1'b0;
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_kind  <= 2'd0;
         rr        <= '0;
      end else begin
         pend <= (pend & ~clr_bits) | set_bits;
         if (ovf_hit)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (out_free) begin
            evt_valid <= found;
            if (found) begin
               evt_id   <= win_id;
               evt_kind <= win_kind;
               rr       <= (win_id == ID_LAST) ? '0 : win_id + ID_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: per-cycle vector table plus hand-written
// sequences for reset, long-press/repeat timing and mid-operation reset.
module tb_button_event_ctrl;

   logic       clk = 1'b0;
   logic       rst_sync;
   logic       tick;
   logic [3:0] btn_level;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_id;
   logic [1:0] evt_kind;
   logic       overflow;
   logic       ovf_clr;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [3:0] btn;
      logic       rdy;
      logic       clr;
      logic       v;
      logic [1:0] id;
      logic [1:0] kind;
      logic       ovf;
   } vec_t;

   vec_t vt [64];
   int   nv = 0;

   logic [11:0] exp_q [$];

   button_event_ctrl dut (
      .clk       (clk),
      .rst_sync  (rst_sync),
      .tick      (tick),
      .btn_level (btn_level),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_kind  (evt_kind),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] btn, input logic rdy, input logic clr,
                      input logic v, input logic [1:0] id, input logic [1:0] kind,
                      input logic ovf);
      vt[nv].btn  = btn;
      vt[nv].rdy  = rdy;
      vt[nv].clr  = clr;
      vt[nv].v    = v;
      vt[nv].id   = id;
      vt[nv].kind = kind;
      vt[nv].ovf  = ovf;
      nv++;
   endtask

   initial begin
      int tick_n;
      bit dropped;

      // Simultaneous presses and round-robin order, starting with rr = 0.
      add(4'b1011, 1, 0, 0, 0, 0, 0);
      add(4'b1011, 1, 0, 1, 0, 0, 0);
      add(4'b1011, 1, 0, 1, 1, 0, 0);
      add(4'b1011, 1, 0, 1, 3, 0, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 1, 0, 3, 0);
      add(4'b0000, 1, 0, 1, 1, 3, 0);
      add(4'b0000, 1, 0, 1, 3, 3, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      add(4'b0100, 1, 0, 0, 0, 0, 0);
      add(4'b0100, 1, 0, 1, 2, 0, 0);
      add(4'b0101, 1, 0, 0, 0, 0, 0);
      add(4'b0101, 1, 0, 1, 0, 0, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 1, 2, 3, 0);
      add(4'b0000, 1, 0, 1, 0, 3, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      // Stalled consumer: press/release toggling on button 1 overflows.
      add(4'b0010, 0, 0, 0, 0, 0, 0);
      add(4'b0000, 0, 0, 1, 1, 0, 0);
      add(4'b0010, 0, 0, 1, 1, 0, 0);
      add(4'b0000, 0, 0, 1, 1, 0, 1);
      add(4'b0010, 0, 0, 1, 1, 0, 1);
      add(4'b0010, 1, 0, 1, 1, 0, 1);
      add(4'b0010, 1, 0, 1, 1, 3, 1);
      add(4'b0010, 1, 0, 0, 0, 0, 1);
      add(4'b0000, 1, 0, 0, 0, 0, 1);
      add(4'b0000, 1, 0, 1, 1, 3, 1);
      add(4'b0000, 1, 0, 0, 0, 0, 1);
      // Overflow clear, and a new overflow colliding with ovf_clr.
      add(4'b0000, 1, 1, 0, 0, 0, 0);
      add(4'b0010, 0, 0, 0, 0, 0, 0);
      add(4'b0000, 0, 0, 1, 1, 0, 0);
      add(4'b0010, 0, 0, 1, 1, 0, 0);
      add(4'b0000, 0, 1, 1, 1, 0, 1);
      add(4'b0000, 0, 1, 1, 1, 0, 0);
      add(4'b0000, 1, 0, 1, 1, 0, 0);
      add(4'b0000, 1, 0, 1, 1, 3, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);

      // Reset for three cycles, then idle observation.
      rst_sync  = 1'b1;
      btn_level = '0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", evt_valid, 0);
      check("rst_id", evt_id, 0);
      check("rst_kind", evt_kind, 0);
      check("rst_ovf", overflow, 0);
      check("rst_tick", tick, 0);
      rst_sync = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         check($sformatf("tick_c%0d", c), tick, (c % 8 == 7) ? 1 : 0);
         check($sformatf("idle_valid_c%0d", c), evt_valid, 0);
      end

      for (int k = 0; k < nv; k++) begin
         @(negedge clk);
         btn_level = vt[k].btn;
         evt_ready = vt[k].rdy;
         ovf_clr   = vt[k].clr;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid", k), evt_valid, vt[k].v);
         check($sformatf("v%0d_ovf", k), overflow, vt[k].ovf);
         if (vt[k].v) begin
            check($sformatf("v%0d_id", k), evt_id, vt[k].id);
            check($sformatf("v%0d_kind", k), evt_kind, vt[k].kind);
         end
      end
      @(negedge clk);
      ovf_clr   = 1'b0;
      evt_ready = 1'b1;

      // Long press on button 2: align the rise to just after a tick.
      begin
         bit seen = 0;
         for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            seen = tick;
         end
         if (!seen) check("tick_align", 0, 1);
      end
      @(negedge clk);
      btn_level = 4'b0100;
      exp_q.push_back({8'd0, 2'd2, 2'd0});
      exp_q.push_back({8'd16, 2'd2, 2'd1});
      exp_q.push_back({8'd20, 2'd2, 2'd2});
      exp_q.push_back({8'd22, 2'd2, 2'd3});
      tick_n  = 0;
      dropped = 0;
      for (int c = 0; c < 400 && !(dropped && exp_q.size() == 0); c++) begin
         @(negedge clk);
         if (evt_valid) begin
            if (exp_q.size() == 0)
               check("lp_extra_evt", {tick_n[7:0], evt_id, evt_kind}, 12'hfff);
            else
               check("lp_evt", {tick_n[7:0], evt_id, evt_kind}, exp_q.pop_front());
         end
         if (tick) tick_n++;
         if (tick && tick_n == 22 && !dropped) begin
            btn_level = 4'b0000;
            dropped   = 1;
         end
      end
      check("lp_left", exp_q.size(), 0);
      check("lp_ovf", overflow, 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("lp_quiet_c%0d", c), evt_valid, 0);
      end

      // Reset while an event is held and another is pending, button 0 held.
      evt_ready = 1'b0;
      btn_level = 4'b0101;
      @(negedge clk);
      @(negedge clk);
      check("mr_pre_valid", evt_valid, 1);
      rst_sync  = 1'b1;
      btn_level = 4'b0001;
      @(posedge clk);
      #1;
      check("mr_valid", evt_valid, 0);
      check("mr_id", evt_id, 0);
      check("mr_kind", evt_kind, 0);
      check("mr_ovf", overflow, 0);
      check("mr_tick", tick, 0);
      rst_sync  = 1'b0;
      evt_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         check($sformatf("mr_valid_c%0d", c), evt_valid, (c == 2) ? 1 : 0);
         if (c == 2) begin
            check("mr_evt_id", evt_id, 0);
            check("mr_evt_kind", evt_kind, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
